// File: rtl/imp_monitor_pkg.sv
// Shared types and constants for the pulse width/period monitor.
package imp_monitor_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } chan_state_e;

    localparam int unsigned N_CH_DEF   = 16;
    localparam int unsigned WID_W_DEF  = 16;
    localparam int unsigned PER_W_DEF  = 32;
    localparam int unsigned SYNC_DEPTH = 2;
    localparam int unsigned CH_IDX_W   = 5;

endpackage

// File: rtl/imp_chan.sv
// One monitored channel: synchroniser, edge detect, WAIT/HIGH/LOW tracker,
// width/period counters, latched results and sticky limit errors.
module imp_chan
    import imp_monitor_pkg::*;
#(
    parameter int unsigned WID_W = WID_W_DEF,
    parameter int unsigned PER_W = PER_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_i,
    input  logic             tus_rise_i,
    input  logic             cfg_we_i,
    input  logic [PER_W-1:0] min_per_i,
    input  logic [WID_W-1:0] max_wid_i,
    input  logic             err_clr_i,
    output logic [WID_W-1:0] wid_o,
    output logic [PER_W-1:0] per_o,
    output logic             err_short_o,
    output logic             err_long_o,
    output logic             fall_c
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  edge_q;
    logic                  rise_c;
    chan_state_e           state_q, state_d;
    logic                  start_c, wid_latch_c, per_latch_c;
    logic [WID_W-1:0]      wid_q, wid_d, wid_lat_q, max_wid_q;
    logic [PER_W-1:0]      per_q, per_d, per_lat_q, min_per_q;
    logic                  short_pend_q, long_pend_q, err_short_q, err_long_q;

    assign rise_c = sync_q[SYNC_DEPTH-1] & ~edge_q;
    assign fall_c = ~sync_q[SYNC_DEPTH-1] & edge_q;

    // Two-stage synchroniser followed by the edge register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], pulse_i};
            edge_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_WAIT;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WAIT: if (rise_c) state_d = ST_HIGH;
            ST_HIGH: if (fall_c) state_d = ST_LOW;
            ST_LOW:  if (rise_c) state_d = ST_HIGH;
            default: state_d = ST_WAIT;
        endcase
    end

    // A rise out of WAIT restarts the counters but has no prior period to latch
    always_comb begin
        start_c     = 1'b0;
        wid_latch_c = 1'b0;
        per_latch_c = 1'b0;
        case (state_q)
            ST_WAIT: start_c = rise_c;
            ST_HIGH: wid_latch_c = fall_c;
            ST_LOW: begin
                start_c     = rise_c;
                per_latch_c = rise_c;
            end
            default: ;
        endcase
    end

    // A tick coinciding with a rise is dropped: the restart to 0 takes priority
    always_comb begin
        wid_d = wid_q;
        per_d = per_q;
        if (start_c)
            wid_d = WID_W'(1);
        else if (state_q == ST_HIGH && wid_q != '1)
            wid_d = wid_q + WID_W'(1);
        if (start_c)
            per_d = '0;
        else if (tus_rise_i && per_q != '1)
            per_d = per_q + PER_W'(1);
    end

    // Limits are compared at the latch edge so a same-edge write cannot affect it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wid_q        <= '0;
            per_q        <= '0;
            wid_lat_q    <= '0;
            per_lat_q    <= '0;
            min_per_q    <= '0;
            max_wid_q    <= '0;
            short_pend_q <= 1'b0;
            long_pend_q  <= 1'b0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
        end else begin
            wid_q <= wid_d;
            per_q <= per_d;
            if (wid_latch_c) wid_lat_q <= wid_q;
            if (per_latch_c) per_lat_q <= per_q;
            if (cfg_we_i) begin
                min_per_q <= min_per_i;
                max_wid_q <= max_wid_i;
            end
            long_pend_q  <= wid_latch_c && (max_wid_q != '0) && (wid_q > max_wid_q);
            short_pend_q <= per_latch_c && (min_per_q != '0) && (per_q < min_per_q);
            err_long_q   <= long_pend_q  | (err_long_q  & ~err_clr_i);
            err_short_q  <= short_pend_q | (err_short_q & ~err_clr_i);
        end
    end

    assign wid_o       = wid_lat_q;
    assign per_o       = per_lat_q;
    assign err_short_o = err_short_q;
    assign err_long_o  = err_long_q;

endmodule

// File: rtl/imp_monitor.sv
// Multi-channel pulse width/period monitor: shared tus synchroniser,
// per-channel trackers, config write decode and registered readback.
module imp_monitor
    import imp_monitor_pkg::*;
#(
    parameter int unsigned N_CH  = N_CH_DEF,
    parameter int unsigned WID_W = WID_W_DEF,
    parameter int unsigned PER_W = PER_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tus,
    input  logic [N_CH-1:0]     i,
    input  logic                cfg_we,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [PER_W-1:0]    cfg_min_per,
    input  logic [WID_W-1:0]    cfg_max_wid,
    input  logic [N_CH-1:0]     err_clr,
    output logic [WID_W-1:0]    rd_wid,
    output logic [PER_W-1:0]    rd_per,
    output logic [N_CH-1:0]     err_short,
    output logic [N_CH-1:0]     err_long,
    output logic                int_event,
    output logic [N_CH-1:0]     fall_mask
);

    logic [SYNC_DEPTH-1:0] tus_sync_q;
    logic                  tus_edge_q;
    logic                  tus_rise_c;
    logic [WID_W-1:0]      wid_lat [N_CH];
    logic [PER_W-1:0]      per_lat [N_CH];
    logic [N_CH-1:0]       fall_c;
    logic [WID_W-1:0]      rd_wid_q, rd_wid_d;
    logic [PER_W-1:0]      rd_per_q, rd_per_d;
    logic [N_CH-1:0]       fall_mask_q;
    logic                  int_event_q;

    // Same depth as the channel path so tick/edge coincidence is preserved
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tus_sync_q <= '0;
            tus_edge_q <= 1'b0;
        end else begin
            tus_sync_q <= {tus_sync_q[SYNC_DEPTH-2:0], tus};
            tus_edge_q <= tus_sync_q[SYNC_DEPTH-1];
        end
    end

    assign tus_rise_c = tus_sync_q[SYNC_DEPTH-1] & ~tus_edge_q;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        imp_chan #(
            .WID_W (WID_W),
            .PER_W (PER_W)
        ) u_chan (
            .clk         (clk),
            .rst         (rst),
            .pulse_i     (i[g]),
            .tus_rise_i  (tus_rise_c),
            .cfg_we_i    (cfg_we && (cfg_ch == CH_IDX_W'(g))),
            .min_per_i   (cfg_min_per),
            .max_wid_i   (cfg_max_wid),
            .err_clr_i   (err_clr[g]),
            .wid_o       (wid_lat[g]),
            .per_o       (per_lat[g]),
            .err_short_o (err_short[g]),
            .err_long_o  (err_long[g]),
            .fall_c      (fall_c[g])
        );
    end

    // Readback mux; indices beyond N_CH fall through to zero
    always_comb begin
        rd_wid_d = '0;
        rd_per_d = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            if (cfg_ch == CH_IDX_W'(k)) begin
                rd_wid_d = wid_lat[k];
                rd_per_d = per_lat[k];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_wid_q    <= '0;
            rd_per_q    <= '0;
            fall_mask_q <= '0;
            int_event_q <= 1'b0;
        end else begin
            rd_wid_q    <= rd_wid_d;
            rd_per_q    <= rd_per_d;
            fall_mask_q <= fall_c;
            int_event_q <= |fall_c;
        end
    end

    assign rd_wid    = rd_wid_q;
    assign rd_per    = rd_per_q;
    assign fall_mask = fall_mask_q;
    assign int_event = int_event_q;

endmodule

// File: tb/tb_imp_monitor.sv
// Directed plus randomized bench for imp_monitor with an event-level reference model.
module tb_imp_monitor;

    localparam int unsigned N  = 16;
    localparam int unsigned WW = 8;
    localparam int unsigned PW = 16;
    localparam int WID_MAX = (1 << WW) - 1;
    localparam int PER_MAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tus_s = 1'b0;
    logic [N-1:0]  pin = '0;
    logic          cfg_we = 1'b0;
    logic [4:0]    cfg_ch = '0;
    logic [PW-1:0] cfg_min_per = '0;
    logic [WW-1:0] cfg_max_wid = '0;
    logic [N-1:0]  err_clr = '0;
    logic [WW-1:0] rd_wid;
    logic [PW-1:0] rd_per;
    logic [N-1:0]  err_short, err_long, fall_mask;
    logic          int_event;

    always #5 clk = ~clk;

    imp_monitor #(.N_CH(N), .WID_W(WW), .PER_W(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .tus         (tus_s),
        .i           (pin),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_min_per (cfg_min_per),
        .cfg_max_wid (cfg_max_wid),
        .err_clr     (err_clr),
        .rd_wid      (rd_wid),
        .rd_per      (rd_per),
        .err_short   (err_short),
        .err_long    (err_long),
        .int_event   (int_event),
        .fall_mask   (fall_mask)
    );

    int compared = 0;
    int mismatched = 0;

    // Reference model: measurements derived from sample times of input edges
    logic [N-1:0] prev_i = '0;
    logic         prev_tus = 1'b0;
    int           t = 0;
    int           tus_tot = 0;
    bit           seen [N];
    int           rise_t [N];
    int           tus_at [N];
    int           m_wid [N];
    int           m_per [N];
    int           lim_per [N];
    int           lim_wid [N];
    logic [N-1:0] m_short = '0;
    logic [N-1:0] m_long = '0;
    int           fall_exp [N];
    int           int_exp = 0;

    int           fall_obs [N];
    int           int_obs = 0;
    int           or_bad = 0;

    always @(negedge clk) begin
        for (int k = 0; k < N; k++)
            if (fall_mask[k] === 1'b1) fall_obs[k]++;
        if (int_event === 1'b1) int_obs++;
        if (int_event !== (|fall_mask)) or_bad++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        prev_i   = '0;
        prev_tus = 1'b0;
        m_short  = '0;
        m_long   = '0;
        for (int k = 0; k < N; k++) begin
            seen[k]    = 1'b0;
            m_wid[k]   = 0;
            m_per[k]   = 0;
            lim_per[k] = 0;
            lim_wid[k] = 0;
        end
    endtask

    // Width = samples spent high; period = tus ticks strictly between two rises
    task automatic model_step();
        int  tr;
        bit  any_fall;
        int  p, w;
        tr       = (tus_s && !prev_tus) ? 1 : 0;
        any_fall = 1'b0;
        t++;
        for (int k = 0; k < N; k++) begin
            if (pin[k] && !prev_i[k]) begin
                if (seen[k]) begin
                    p = tus_tot - tus_at[k];
                    if (p > PER_MAX) p = PER_MAX;
                    m_per[k] = p;
                    if (lim_per[k] != 0 && p < lim_per[k]) m_short[k] = 1'b1;
                end
                seen[k]   = 1'b1;
                rise_t[k] = t;
                tus_at[k] = tus_tot + tr;
            end else if (!pin[k] && prev_i[k] && seen[k]) begin
                w = t - rise_t[k];
                if (w > WID_MAX) w = WID_MAX;
                m_wid[k] = w;
                if (lim_wid[k] != 0 && w > lim_wid[k]) m_long[k] = 1'b1;
                fall_exp[k]++;
                any_fall = 1'b1;
            end
        end
        if (any_fall) int_exp++;
        tus_tot += tr;
        prev_i   = pin;
        prev_tus = tus_s;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic tus_ticks(input int n);
        repeat (n) begin
            tus_s = 1'b0;
            tick();
            tus_s = 1'b1;
            tick();
        end
    endtask

    task automatic write_cfg(input int ch, input int mp, input int mw);
        cfg_we      = 1'b1;
        cfg_ch      = 5'(ch);
        cfg_min_per = PW'(mp);
        cfg_max_wid = WW'(mw);
        tick();
        cfg_we = 1'b0;
        if (ch < N) begin
            lim_per[ch] = mp;
            lim_wid[ch] = mw;
        end
    endtask

    task automatic clear_err(input logic [N-1:0] mask);
        err_clr = mask;
        tick();
        err_clr = '0;
        m_short &= ~mask;
        m_long  &= ~mask;
    endtask

    task automatic check_ch(input int ch);
        cfg_ch = 5'(ch);
        tick();
        chk($sformatf("rd_wid[%0d]", ch), 32'(rd_wid), 32'(m_wid[ch]));
        chk($sformatf("rd_per[%0d]", ch), 32'(rd_per), 32'(m_per[ch]));
    endtask

    task automatic check_errs(input string tag);
        chk({tag, "_err_short"}, 32'(err_short), 32'(m_short));
        chk({tag, "_err_long"},  32'(err_long),  32'(m_long));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_wid"},    32'(rd_wid),    0);
        chk({tag, "_rd_per"},    32'(rd_per),    0);
        chk({tag, "_err_short"}, 32'(err_short), 0);
        chk({tag, "_err_long"},  32'(err_long),  0);
        chk({tag, "_fall_mask"}, 32'(fall_mask), 0);
        chk({tag, "_int_event"}, 32'(int_event), 0);
    endtask

    task automatic wait_fall(input string tag, input logic [N-1:0] exp_mask);
        bit found;
        found = 1'b0;
        for (int n = 0; n < 8 && !found; n++) begin
            tick();
            if (fall_mask != '0) found = 1'b1;
        end
        chk({tag, "_seen"},     32'(found),     1);
        chk({tag, "_mask"},     32'(fall_mask), 32'(exp_mask));
        chk({tag, "_int"},      32'(int_event), 1);
        tick();
        chk({tag, "_mask_off"}, 32'(fall_mask), 0);
        chk({tag, "_int_off"},  32'(int_event), 0);
    endtask

    initial begin
        logic [N-1:0] flip;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        // First rise after reset latches no period; the second latches 10 ticks
        pin[2] = 1'b1;
        tus_ticks(5);
        pin[2] = 1'b0;
        tus_ticks(5);
        idle(6);
        check_ch(2);
        chk("first_rise_per", 32'(rd_per), 0);
        chk("first_rise_wid", 32'(rd_wid), 10);
        pin[2] = 1'b1;
        tus_ticks(2);
        pin[2] = 1'b0;
        idle(6);
        check_ch(2);
        chk("second_rise_per", 32'(rd_per), 10);

        // ch3: 100-cycle pulse, rises 50 ticks apart
        pin[3] = 1'b1;
        idle(100);
        pin[3] = 1'b0;
        wait_fall("ch3_fall", 16'h0008);
        tus_ticks(50);
        pin[3] = 1'b1;
        idle(6);
        check_ch(3);
        chk("ch3_wid", 32'(rd_wid), 100);
        chk("ch3_per", 32'(rd_per), 50);
        pin[3] = 1'b0;
        idle(6);

        // Simultaneous falls, then a tick coincident with the next rise
        pin[1] = 1'b1;
        pin[7] = 1'b1;
        idle(20);
        pin[1] = 1'b0;
        pin[7] = 1'b0;
        wait_fall("dual_fall", 16'h0082);
        tus_ticks(7);
        tus_s = 1'b0;
        tick();
        pin[1] = 1'b1;
        tus_s  = 1'b1;
        tick();
        tus_s = 1'b0;
        idle(6);
        check_ch(1);
        chk("coincident_per", 32'(rd_per), 7);
        pin[1] = 1'b0;
        idle(6);

        // ch0 short-period error: sticky, cleared by write-1
        write_cfg(0, 1000, 0);
        pin[0] = 1'b1;
        idle(4);
        pin[0] = 1'b0;
        tus_ticks(256);
        pin[0] = 1'b1;
        idle(4);
        pin[0] = 1'b0;
        idle(8);
        check_ch(0);
        chk("short_per_256", 32'(rd_per), 256);
        chk("short_set", 32'(err_short[0]), 1);
        idle(20);
        chk("short_sticky", 32'(err_short[0]), 1);
        check_errs("short");
        clear_err(16'h0001);
        idle(2);
        chk("short_cleared", 32'(err_short[0]), 0);

        // Clear pulse lands on the edge where the error sets: set must win
        tus_ticks(3);
        pin[0] = 1'b1;
        tick();
        tick();
        tick();
        err_clr[0] = 1'b1;
        tick();
        err_clr[0] = 1'b0;
        chk("set_wins", 32'(err_short[0]), 1);
        pin[0] = 1'b0;
        idle(6);
        check_errs("set_wins");

        // Width saturation and long-width error
        write_cfg(4, 0, 200);
        pin[4] = 1'b1;
        idle(300);
        pin[4] = 1'b0;
        idle(8);
        check_ch(4);
        chk("wid_sat", 32'(rd_wid), 255);
        chk("long_set", 32'(err_long[4]), 1);

        // Out-of-range channel: write ignored, read returns zero
        write_cfg(20, 5, 5);
        cfg_ch = 5'd20;
        tick();
        chk("oor_rd_wid", 32'(rd_wid), 0);
        chk("oor_rd_per", 32'(rd_per), 0);

        // Reset mid-pulse on ch5
        cfg_ch = 5'd3;
        pin[5] = 1'b1;
        idle(20);
        #2 rst = 1'b1;
        #1 check_zero("async_rst");
        pin   = '0;
        tus_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        idle(3);
        pin[5] = 1'b1;
        idle(37);
        pin[5] = 1'b0;
        idle(6);
        check_ch(5);
        chk("post_rst_wid", 32'(rd_wid), 37);
        chk("post_rst_per", 32'(rd_per), 0);
        tus_ticks(4);
        pin[5] = 1'b1;
        idle(3);
        pin[5] = 1'b0;
        idle(6);
        check_ch(5);
        chk("post_rst_per2", 32'(rd_per), 4);
        pin[0] = 1'b1; idle(2); pin[0] = 1'b0; idle(2);
        pin[0] = 1'b1; idle(2); pin[0] = 1'b0; idle(8);
        check_errs("limits_cleared");

        // Randomized traffic against the model
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N; k++)
                write_cfg(k, int'($urandom_range(0, 12)), int'($urandom_range(0, 20)));
            for (int c = 0; c < 3000; c++) begin
                flip  = N'($urandom & $urandom & $urandom);
                pin   = pin ^ flip;
                tus_s = 1'($urandom_range(0, 1));
                tick();
            end
            idle(8);
            for (int k = 0; k < N; k++) check_ch(k);
            check_errs($sformatf("rand%0d", r));
            clear_err('1);
            idle(3);
            check_errs($sformatf("rand%0d_clr", r));
        end

        pin = '0;
        idle(8);
        for (int k = 0; k < N; k++)
            chk($sformatf("fall_count[%0d]", k), 32'(fall_obs[k]), 32'(fall_exp[k]));
        chk("int_count", 32'(int_obs), 32'(int_exp));
        chk("int_is_or", 32'(or_bad), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/imp_monitor.md
IMP_MONITOR -- requirements
Module: imp_monitor

Interface
REQ-001 Parameter N_CH, default 16: number of monitored pulse inputs, 1..32.
REQ-002 Parameter WID_W, default 16: width of the pulse-width counter, in clk cycles.
REQ-003 Parameter PER_W, default 32: width of the period counter, in tus strobes.
REQ-004 Port clk  in  1: single clock for all logic.
REQ-005 Port rst  in  1: reset, asynchronous and active-high.
REQ-006 Port tus  in  1: asynchronous microsecond tick, used as the period time base.
REQ-007 Port i  in  N_CH: asynchronous pulse inputs, one per channel.
REQ-008 Port cfg_we  in  1: one-cycle write strobe for channel limits.
REQ-009 Port cfg_ch  in  5: channel index for writes and reads.
REQ-010 Port cfg_min_per  in  PER_W: minimum allowed period for cfg_ch; 0 disables the check.
REQ-011 Port cfg_max_wid  in  WID_W: maximum allowed width for cfg_ch; 0 disables the check.
REQ-012 Port err_clr  in  N_CH: write-1-to-clear for sticky errors.
REQ-013 Port rd_wid  out  WID_W: last latched width of cfg_ch, registered.
REQ-014 Port rd_per  out  PER_W: last latched period of cfg_ch, registered.
REQ-015 Port err_short  out  N_CH: sticky flag, period below limit.
REQ-016 Port err_long  out  N_CH: sticky flag, width above limit.
REQ-017 Port int_event  out  1: one-cycle pulse on any channel falling edge.
REQ-018 Port fall_mask  out  N_CH: per-channel one-cycle falling-edge flags.

Function
REQ-019 Each i bit and tus SHALL pass through a 2-FF synchroniser and then a 1-FF edge register; edge detection is declared 3 clk after the input transition.
REQ-020 Each channel SHALL run a 3-state FSM: WAIT (no rising edge seen yet), HIGH, LOW.
  - WAIT->HIGH on rise.
  - HIGH->LOW on fall.
  - LOW->HIGH on rise.
REQ-021 In HIGH, the width counter SHALL increment every clk and saturate at all-ones; it clears to 1 on rise.
REQ-022 On fall, the width SHALL be latched into the channel width register, the matching fall_mask bit asserted for exactly 1 clk, and int_event = OR(fall_mask) in the same cycle.
REQ-023 The period counter SHALL increment on each synchronised tus rising edge and saturate at all-ones.
  - On rise in LOW, the counter value is latched as the period and the counter restarts at 0.
  - On rise from WAIT, nothing is latched.
REQ-024 If a tus edge and a channel rise coincide, the latched period SHALL exclude that tick and the counter SHALL restart at 0.
REQ-025 At period latch: if cfg_min_per[ch]!=0 and period<cfg_min_per[ch], err_short[ch] SHALL set, 1 clk after the latch.
REQ-026 At width latch: if cfg_max_wid[ch]!=0 and width>cfg_max_wid[ch], err_long[ch] SHALL set, 1 clk after the latch.
REQ-027 When error set and err_clr fall in the same cycle, set SHALL win.
REQ-028 cfg_we SHALL write both limits for cfg_ch at the next clk edge; writes with cfg_ch>=N_CH are ignored.
REQ-029 rd_wid/rd_per SHALL reflect cfg_ch with 1-clk latency; an out-of-range index reads 0.
REQ-030 A new limit SHALL apply only to latches occurring after the write edge.

Reset
REQ-031 rst SHALL asynchronously clear all of the following:
  - synchronisers and FSMs (to WAIT);
  - counters, latched widths and periods;
  - limits (checks disabled);
  - err_short, err_long, fall_mask, int_event, rd_wid, rd_per.
REQ-032 rst asserted mid-pulse SHALL discard the partial measurement; after release, the first rise re-enters HIGH from WAIT with no period latch.

Structure
REQ-033 Package imp_monitor_pkg SHALL hold:
  - FSM state enum (WAIT, HIGH, LOW);
  - default parameter constants;
  - the sync depth constant, value 2.
REQ-034 Sub-module imp_chan SHALL implement one channel (sync, edge, FSM, counters, limit compare); imp_monitor instantiates N_CH copies via generate and adds the config/read mux and the OR-reduction.

Verification
REQ-035 ch3: pulse 100 clk high, rise-to-rise spacing 50 tus -> rd_wid=100, rd_per=50, fall_mask[3] 1 clk, int_event 1 clk.
REQ-036 ch0 cfg_min_per=1000, two rises 256 tus apart -> err_short[0]=1 and stays set; err_clr[0] pulse -> 0.
REQ-037 WID_W=8, pulse 300 clk -> rd_wid=255; with cfg_max_wid=200 -> err_long set.
REQ-038 First rise after reset -> no period latched, rd_per=0; second rise 10 tus later -> rd_per=10.
REQ-039 rst asserted during HIGH of ch5 -> all outputs 0 asynchronously; next complete pulse measured correctly.
REQ-040 Simultaneous falls on ch1 and ch7 -> fall_mask=0x0082, single-cycle int_event; tus coincident with rise -> period excludes that tick.
